bram_stream_reader: RTL and testbench

- Read-side controller for the simple-dual-port BRAM wrapper.
- Accepts a burst request (start address, length) and drives the RAM read address.
- Realigns RAM read data with a fixed RD_LATENCY delay line and presents it as a valid/ready stream with a last flag.
- Downstream backpressure uses credit-based issue into an output FIFO. RAM data is never dropped, and no read is issued that cannot be stored.

---
 rtl/bram_stream_reader.sv | 179 +++++++++++++++++
 tb/tb_bram_stream_reader.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : bram_stream_reader
// Burst reader for a BRAM read port: realigns q and streams it through a credit-gated FIFO.
// Rev    : 1.0
// ============================================================================
module bram_stream_reader #(
    parameter int  DATA_WIDTH = 256,
    parameter int  NUMWORDS   = 256,
    parameter int  RD_LATENCY = 3,
    parameter int  FIFO_DEPTH = 8,
    localparam int AW         = $clog2(NUMWORDS)
) (
    input  logic                  clock,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [AW-1:0]         req_addr,
    input  logic [AW:0]           req_len,
    output logic [AW-1:0]         rdaddress,
    input  logic [DATA_WIDTH-1:0] q,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_last,
    output logic                  busy
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [AW-1:0]         addr_q, addr_d;
    logic [AW:0]           remaining_q, remaining_d;
    logic [AW-1:0]         rdaddress_q, rdaddress_d;
    logic [RD_LATENCY:0]   pipe_vld_q, pipe_vld_d;
    logic [RD_LATENCY:0]   pipe_last_q, pipe_last_d;
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic [DATA_WIDTH:0]   fifo_mem_q [FIFO_DEPTH];
    logic [DATA_WIDTH:0]   fifo_mem_d [FIFO_DEPTH];

    logic                  issue;
    logic                  issue_last;
    logic                  capture;
    logic                  cap_last;
    logic                  pop;
    logic                  fifo_empty;
    logic                  fifo_full;
    logic                  credit_ok;
    logic [CW-1:0]         inflight;
    logic [DATA_WIDTH:0]   head;

    // Stage 0 of the pipe lines up with rdaddress; stage RD_LATENCY lines up with q.
    assign capture    = pipe_vld_q[RD_LATENCY];
    assign cap_last   = pipe_last_q[RD_LATENCY];
    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == CW'(FIFO_DEPTH));
    assign pop        = !fifo_empty && m_ready;
    assign head       = fifo_mem_q[rd_ptr_q];

    assign req_ready  = (state_q == IDLE);
    assign busy       = (state_q != IDLE);
    assign rdaddress  = rdaddress_q;
    assign m_valid    = !fifo_empty;
    assign m_data     = fifo_empty ? '0 : head[DATA_WIDTH:1];
    assign m_last     = !fifo_empty && head[0];

    always_comb begin
        inflight = '0;
        for (int i = 0; i <= RD_LATENCY; i++) begin
            inflight = inflight + CW'(pipe_vld_q[i]);
        end
    end

    assign credit_ok = ({1'b0, inflight} + {1'b0, count_q}) < (CW + 1)'(FIFO_DEPTH);

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        remaining_d = remaining_q;
        rdaddress_d = rdaddress_q;
        issue       = 1'b0;
        issue_last  = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid && (req_len != '0)) begin
                    addr_d      = req_addr;
                    remaining_d = req_len;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                if (credit_ok) begin
                    issue       = 1'b1;
                    issue_last  = (remaining_q == (AW + 1)'(1));
                    rdaddress_d = addr_q;
                    addr_d      = addr_q + AW'(1);
                    remaining_d = remaining_q - (AW + 1)'(1);
                    if (issue_last) begin
                        state_d = DRAIN;
                    end
                end
            end
            DRAIN: begin
                if (pop && m_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        pipe_vld_d  = {pipe_vld_q[RD_LATENCY-1:0], issue};
        pipe_last_d = {pipe_last_q[RD_LATENCY-1:0], issue_last};
    end

    always_comb begin
        fifo_mem_d = fifo_mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        if (capture) begin
            fifo_mem_d[wr_ptr_q] = {q, cap_last};
            wr_ptr_d             = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        case ({capture, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clock) begin
        if (rst) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            remaining_q <= '0;
            rdaddress_q <= '0;
            pipe_vld_q  <= '0;
            pipe_last_q <= '0;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            remaining_q <= remaining_d;
            rdaddress_q <= rdaddress_d;
            pipe_vld_q  <= pipe_vld_d;
            pipe_last_q <= pipe_last_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    // Storage only; occupancy is governed by the pointers and count.
    always_ff @(posedge clock) begin
        fifo_mem_q <= fifo_mem_d;
    end

    a_no_overflow: assert property (@(posedge clock) disable iff (rst) !(capture && fifo_full));
    a_credit: assert property (@(posedge clock) disable iff (rst)
        ({1'b0, inflight} + {1'b0, count_q}) <= (CW + 1)'(FIFO_DEPTH));

endmodule
`default_nettype wire

// File: tb/tb_bram_stream_reader.sv
`default_nettype none
// ============================================================================
// Module : tb_bram_stream_reader
// Directed bench: RAM model holds word[i]=i; burst table plus hand-written corner sequences.
// Rev    : 1.0
// ============================================================================
module tb_bram_stream_reader;

    logic         clock = 1'b0;
    logic         rst;
    logic         req_valid;
    logic         req_ready;
    logic [7:0]   req_addr;
    logic [8:0]   req_len;
    logic [7:0]   rdaddress;
    logic [255:0] ram_q;
    logic         m_valid;
    logic         m_ready;
    logic [255:0] m_data;
    logic         m_last;
    logic         busy;

    int passed = 0;
    int total  = 0;

    typedef struct {
        string        name;
        logic [7:0]   addr;
        logic [8:0]   len;
        int           mode;
        int           exp_lat;
        logic [255:0] exp_first;
        logic [255:0] exp_lastw;
    } burst_t;

    burst_t tbl [5];

    bram_stream_reader #(
        .DATA_WIDTH(256),
        .NUMWORDS  (256),
        .RD_LATENCY(3),
        .FIFO_DEPTH(8)
    ) dut (
        .clock    (clock),
        .rst      (rst),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_addr (req_addr),
        .req_len  (req_len),
        .rdaddress(rdaddress),
        .q        (ram_q),
        .m_valid  (m_valid),
        .m_ready  (m_ready),
        .m_data   (m_data),
        .m_last   (m_last),
        .busy     (busy)
    );

    always #5 clock = ~clock;

    // Three-register RAM read path; word i holds the value i.
    logic [7:0]   ram_a1;
    logic [255:0] ram_d2;
    always @(posedge clock) begin
        ram_a1 <= rdaddress;
        ram_d2 <= 256'(ram_a1);
        ram_q  <= ram_d2;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    task automatic chk_b(input string name, input logic act, input logic exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0b expected %0b", name, act, exp);
    endtask

    task automatic chk_i(input string name, input int act, input int exp);
        total++;
        if (act == exp) passed++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    function automatic logic ready_at(input int mode, input int k);
        if (mode == 0) return 1'b1;
        if (k < 40) return (k % 3) == 0;
        if (k < 60) return 1'b0;
        return 1'b1;
    endfunction

    task automatic run_burst(input burst_t b);
        int           k;
        int           nwords;
        int           nlast;
        int           first_k;
        logic         done;
        logic         prev_stall;
        logic [255:0] prev_data;
        logic [255:0] first_w;
        logic [255:0] last_w;
        k = 0; nwords = 0; nlast = 0; first_k = -1;
        done = 1'b0; prev_stall = 1'b0;
        prev_data = '0; first_w = '0; last_w = '0;
        req_addr  = b.addr;
        req_len   = b.len;
        req_valid = 1'b1;
        m_ready   = 1'b1;
        chk_b({b.name, " req_ready"}, req_ready, 1'b1);
        tick();
        req_valid = 1'b0;
        chk_b({b.name, " busy"}, busy, 1'b1);
        while (!done && k < 3000) begin
            m_ready = ready_at(b.mode, k);
            if (prev_stall) begin
                chk_b({b.name, " stall valid"}, m_valid, 1'b1);
                check({b.name, " stall data"}, m_data, prev_data);
            end
            if (m_valid && first_k < 0) first_k = k;
            if (m_valid && m_ready) begin
                check({b.name, " data"}, m_data, 256'((int'(b.addr) + nwords) % 256));
                chk_b({b.name, " last flag"}, m_last, nwords == int'(b.len) - 1);
                if (nwords == 0) first_w = m_data;
                last_w = m_data;
                if (m_last) begin
                    nlast++;
                    done = 1'b1;
                end
                nwords++;
            end
            prev_stall = m_valid && !m_ready;
            prev_data  = m_data;
            tick();
            k++;
        end
        m_ready = 1'b1;
        chk_b({b.name, " completed"}, done, 1'b1);
        chk_i({b.name, " word count"}, nwords, int'(b.len));
        chk_i({b.name, " last count"}, nlast, 1);
        chk_i({b.name, " first latency"}, first_k, b.exp_lat);
        check({b.name, " first word"}, first_w, b.exp_first);
        check({b.name, " final word"}, last_w, b.exp_lastw);
        chk_b({b.name, " busy after"}, busy, 1'b0);
        chk_b({b.name, " ready after"}, req_ready, 1'b1);
        chk_b({b.name, " empty after"}, m_valid, 1'b0);
    endtask

    initial begin
        int           k;
        int           acc2_k;
        int           pop6_k;
        int           nout;
        logic         any_valid;
        logic         any_notready;
        logic [255:0] got [5];
        logic         gotl [5];
        logic [255:0] exp_d [5];
        logic         exp_l [5];

        tbl[0] = '{"basic",  8'd10,  9'd4,   0, 5, 256'd10,  256'd13};
        tbl[1] = '{"wrap",   8'd254, 9'd4,   0, 5, 256'd254, 256'd1};
        tbl[2] = '{"bp",     8'd0,   9'd32,  1, 5, 256'd0,   256'd31};
        tbl[3] = '{"full",   8'd100, 9'd256, 0, 5, 256'd100, 256'd99};
        tbl[4] = '{"single", 8'd255, 9'd1,   0, 5, 256'd255, 256'd255};

        rst = 1'b1; req_valid = 1'b0; req_addr = '0; req_len = '0; m_ready = 1'b0;
        repeat (3) tick();
        chk_b("reset req_ready", req_ready, 1'b1);
        chk_b("reset m_valid", m_valid, 1'b0);
        chk_b("reset m_last", m_last, 1'b0);
        check("reset m_data", m_data, '0);
        chk_b("reset busy", busy, 1'b0);
        check("reset rdaddress", 256'(rdaddress), '0);
        rst = 1'b0;
        tick();

        for (int i = 0; i < 5; i++) begin
            run_burst(tbl[i]);
            repeat (2) tick();
        end

        // Zero-length request is consumed without producing anything.
        req_addr = 8'd7; req_len = 9'd0; req_valid = 1'b1; m_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        any_valid = 1'b0; any_notready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid) any_valid = 1'b1;
            if (!req_ready || busy) any_notready = 1'b1;
            tick();
        end
        chk_b("len0 no output", any_valid, 1'b0);
        chk_b("len0 stays ready", any_notready, 1'b0);

        // rdaddress sequence across the wrap point.
        req_addr = 8'd254; req_len = 9'd4; req_valid = 1'b1;
        tick();
        req_valid = 1'b0;
        tick(); check("wrap rdaddr0", 256'(rdaddress), 256'd254);
        tick(); check("wrap rdaddr1", 256'(rdaddress), 256'd255);
        tick(); check("wrap rdaddr2", 256'(rdaddress), 256'd0);
        tick(); check("wrap rdaddr3", 256'(rdaddress), 256'd1);
        k = 0;
        while (busy && k < 100) begin tick(); k++; end
        chk_b("wrap drained", busy, 1'b0);
        repeat (2) tick();

        // Back-to-back: second request held valid while the first drains.
        exp_d = '{256'd5, 256'd6, 256'd50, 256'd51, 256'd52};
        exp_l = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        req_addr = 8'd5; req_len = 9'd2; req_valid = 1'b1;
        tick();
        req_addr = 8'd50; req_len = 9'd3;
        k = 0; acc2_k = -1; pop6_k = -1; nout = 0;
        while (k < 200 && nout < 5) begin
            if (req_valid && req_ready) acc2_k = k;
            if (m_valid && m_ready) begin
                got[nout]  = m_data;
                gotl[nout] = m_last;
                if (m_data == 256'd6) pop6_k = k;
                nout++;
            end
            tick();
            if (acc2_k >= 0) req_valid = 1'b0;
            k++;
        end
        req_valid = 1'b0;
        chk_i("b2b count", nout, 5);
        for (int i = 0; i < 5; i++) begin
            check("b2b data", got[i], exp_d[i]);
            chk_b("b2b last", gotl[i], exp_l[i]);
        end
        chk_b("b2b pop seen", pop6_k >= 0, 1'b1);
        chk_i("b2b accept timing", acc2_k, pop6_k + 1);
        k = 0;
        while (busy && k < 100) begin tick(); k++; end
        repeat (2) tick();

        // Reset pulse while word 6 is at the head of a 16-word burst.
        req_addr = 8'd0; req_len = 9'd16; req_valid = 1'b1; m_ready = 1'b1;
        tick();
        req_valid = 1'b0;
        k = 0;
        while (!(m_valid && m_data == 256'd6) && k < 100) begin tick(); k++; end
        chk_b("rst head reached", m_valid, 1'b1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk_b("rst m_valid", m_valid, 1'b0);
        chk_b("rst req_ready", req_ready, 1'b1);
        chk_b("rst busy", busy, 1'b0);
        any_valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            if (m_valid) any_valid = 1'b1;
            tick();
        end
        chk_b("rst no stale", any_valid, 1'b0);
        run_burst('{"post_rst", 8'd200, 9'd2, 0, 5, 256'd200, 256'd201});

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
`default_nettype wire
